// File: rtl/life_step_engine.sv
// One cellular-automaton generation over a W x H 1-bit grid using a sliding 3x3 window.
// Define LIFE_WRAP_EN for a toroidal grid; otherwise the border reads as dead.
//   state   | meaning
//   S_IDLE  | waiting for start; outputs hold
//   S_FETCH | 4-cycle column fetch into the R window column
//   S_WRITE | emit one next-generation cell
//   S_DONE  | 1-cycle end-of-generation pulse
module life_step_engine #(
  parameter int W  = 160,
  parameter int H  = 120,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [8:0]    rule_birth,
  input  logic [8:0]    rule_survive,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_data,
  output logic [AW-1:0] wr_addr,
  output logic          wr_data,
  output logic          wr_en,
  output logic          busy,
  output logic          done,
  output logic          bank,
  output logic [14:0]   population
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] TWO       = AW'(2);
  localparam logic [AW-1:0] W_A       = AW'(W);
  localparam logic [AW-1:0] WP1       = AW'(W + 1);
  localparam logic [AW-1:0] HM1       = AW'(H - 1);
  localparam logic [AW-1:0] LAST_BASE = AW'((H - 1) * W);

  state_t        state, state_nx;
  logic [1:0]    k;
  logic [AW-1:0] c;          // fetched column + 1 (0 = column -1)
  logic [AW-1:0] y;
  logic [AW-1:0] row_base;
  logic [2:0]    win_l, win_c, win_r;
  logic [8:0]    birth_q, survive_q;
  logic          rd_en, rd_valid_q;
  logic [AW-1:0] rd_addr_q, wr_addr_q;
  logic [AW-1:0] col, rbase;
  logic [3:0]    n;
  logic          rule_bit;
  logic          last_cell;

  assign busy      = (state == S_FETCH) || (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign wr_en     = (state == S_WRITE);
  assign wr_data   = wr_en & rule_bit;
  assign wr_addr   = wr_en ? (row_base + c - TWO) : wr_addr_q;
  assign last_cell = (c == WP1) && (y == HM1);

  always_comb begin
    n = {3'b0, win_l[0]} + {3'b0, win_l[1]} + {3'b0, win_l[2]}
      + {3'b0, win_c[0]} + {3'b0, win_c[2]}
      + {3'b0, win_r[0]} + {3'b0, win_r[1]} + {3'b0, win_r[2]};
    rule_bit = win_c[1] ? survive_q[n] : birth_q[n];
  end

  // Off-grid reads are suppressed in the dead-border build; the address then holds.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = rd_addr_q;
    col     = '0;
    rbase   = row_base;
    if (state == S_FETCH && k != 2'd3) begin
      if (c == '0)       col = W_A - ONE;
      else if (c == WP1) col = '0;
      else               col = c - ONE;
      case (k)
        2'd0:    rbase = (y == '0) ? LAST_BASE : row_base - W_A;
        2'd2:    rbase = (y == HM1) ? '0 : row_base + W_A;
        default: rbase = row_base;
      endcase
`ifdef LIFE_WRAP_EN
      rd_en = 1'b1;
`else
      rd_en = (c != '0) && (c != WP1)
              && !(k == 2'd0 && y == '0) && !(k == 2'd2 && y == HM1);
`endif
      if (rd_en) rd_addr = rbase + col;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: if (k == 2'd3) state_nx = (c >= TWO) ? S_WRITE : S_FETCH;
      S_WRITE: state_nx = last_cell ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= '0;
      c          <= '0;
      y          <= '0;
      row_base   <= '0;
      win_l      <= '0;
      win_c      <= '0;
      win_r      <= '0;
      birth_q    <= '0;
      survive_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      population <= '0;
      bank       <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_valid_q <= rd_en;
      rd_addr_q  <= rd_addr;
      wr_addr_q  <= wr_addr;
      case (state)
        S_IDLE: begin
          if (start) begin
            birth_q    <= rule_birth;
            survive_q  <= rule_survive;
            population <= '0;
            y          <= '0;
            row_base   <= '0;
            c          <= '0;
            k          <= '0;
          end
        end
        S_FETCH: begin
          if (k == 2'd0) begin
            win_l <= win_c;
            win_c <= win_r;
          end else begin
            win_r[k - 2'd1] <= rd_valid_q & rd_data;
          end
          k <= k + 2'd1;
          if (k == 2'd3 && c < TWO) c <= c + ONE;
        end
        S_WRITE: begin
          if (wr_data && population != 15'h7fff) population <= population + 15'd1;
          if (last_cell) bank <= ~bank;
          if (c == WP1) begin
            c        <= '0;
            y        <= y + ONE;
            row_base <= row_base + W_A;
          end else begin
            c <= c + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine on a reduced 16x14 grid with a 1-cycle-latency cell RAM model.
module tb_life_step_engine;
  localparam int W     = 16;
  localparam int H     = 14;
  localparam int AW    = 20;
  localparam int N     = W * H;
  localparam int LAT   = H * (W * 5 + 8);
  localparam int LIMIT = LAT + 200;
  localparam int NV    = 7;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [8:0]    rule_birth, rule_survive;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_data = 1'b0;
  logic          wr_data, wr_en, busy, done, bank;
  logic [14:0]   population;

  life_step_engine #(.W(W), .H(H), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rule_birth(rule_birth), .rule_survive(rule_survive),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done), .bank(bank), .population(population)
  );

  always #5 clk = ~clk;

  logic mem [N];
  logic got [N];
  int   seq [N];
  int   wr_total = 0;

  always @(posedge clk) begin
    if (int'(rd_addr) < N) rd_data <= mem[rd_addr];
    if (wr_en) begin
      if (int'(wr_addr) < N) begin
        got[wr_addr] <= wr_data;
        seq[wr_addr] <= wr_total;
      end
      wr_total <= wr_total + 1;
    end
  end

  typedef struct {
    logic [8:0]       birth;
    logic [8:0]       survive;
    int               nin;
    logic [7:0][15:0] in_c;
    int               nout;
    logic [3:0][15:0] out_c;
    bit               all_out;
    int               pop;
  } vec_t;

  vec_t vecs [NV];
  int   nvec = 0;
  int   nmis = 0;
  logic exp_bank = 1'b0;

  function automatic logic [15:0] idx(input int x, input int y);
    return 16'(y * W + x);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic load(input vec_t t);
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
    for (int j = 0; j < t.nin; j++) mem[t.in_c[j]] = 1'b1;
  endtask

  task automatic pulse_start(input vec_t t);
    @(negedge clk);
    rule_birth = t.birth; rule_survive = t.survive; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_frame(input vec_t t, input int id, input int base);
    logic eg [N];
    int bad_grid, bad_order;
    for (int i = 0; i < N; i++) eg[i] = t.all_out;
    for (int j = 0; j < t.nout; j++) eg[t.out_c[j]] = 1'b1;
    bad_grid = 0; bad_order = 0;
    for (int i = 0; i < N; i++) begin
      if (got[i] !== eg[i]) bad_grid++;
      if (seq[i] != base + i) bad_order++;
    end
    chk($sformatf("v%0d population", id), int'(population), t.pop);
    chk($sformatf("v%0d write count", id), wr_total - base, N);
    chk($sformatf("v%0d grid cells wrong", id), bad_grid, 0);
    chk($sformatf("v%0d write order errors", id), bad_order, 0);
  endtask

  task automatic run_vec(input vec_t t, input int id);
    int base, cyc;
    load(t);
    base = wr_total;
    pulse_start(t);
    chk($sformatf("v%0d busy after start", id), int'(busy), 1);
    cyc = 1;
    while (cyc < LIMIT) begin
      @(posedge clk); #1;
      if (done) break;
      cyc++;
    end
    exp_bank = ~exp_bank;
    chk($sformatf("v%0d done latency", id), cyc, LAT);
    chk($sformatf("v%0d bank", id), int'(bank), int'(exp_bank));
    chk($sformatf("v%0d busy in done", id), int'(busy), 0);
    check_frame(t, id, base);
    @(posedge clk); #1;
    chk($sformatf("v%0d done single pulse", id), int'(done), 0);
    chk($sformatf("v%0d population held", id), int'(population), t.pop);
  endtask

  initial begin
    int cyc, dones, base, w0;
    reset = 1'b1; start = 1'b0; rule_birth = '0; rule_survive = '0;
    for (int i = 0; i < N; i++) mem[i] = 1'b0;

    for (int v = 0; v < NV; v++) begin
      vecs[v].birth = 9'h008; vecs[v].survive = 9'h00C;
      vecs[v].nin = 0; vecs[v].in_c = '0; vecs[v].nout = 0; vecs[v].out_c = '0;
      vecs[v].all_out = 1'b0; vecs[v].pop = 0;
    end
    // blinker
    vecs[0].nin = 3;  vecs[0].in_c[0] = idx(10, 9); vecs[0].in_c[1] = idx(10, 10); vecs[0].in_c[2] = idx(10, 11);
    vecs[0].nout = 3; vecs[0].out_c[0] = idx(9, 10); vecs[0].out_c[1] = idx(10, 10); vecs[0].out_c[2] = idx(11, 10);
    vecs[0].pop = 3;
    // still-life block
    vecs[1].nin = 4;
    vecs[1].in_c[0] = idx(5, 6); vecs[1].in_c[1] = idx(6, 6); vecs[1].in_c[2] = idx(5, 7); vecs[1].in_c[3] = idx(6, 7);
    vecs[1].nout = 4;
    vecs[1].out_c[0] = idx(5, 6); vecs[1].out_c[1] = idx(6, 6); vecs[1].out_c[2] = idx(5, 7); vecs[1].out_c[3] = idx(6, 7);
    vecs[1].pop = 4;
`ifdef LIFE_WRAP_EN
    vecs[2].nin = 3;  vecs[2].in_c[0] = idx(W - 1, 0); vecs[2].in_c[1] = idx(0, 0); vecs[2].in_c[2] = idx(1, 0);
    vecs[2].nout = 3; vecs[2].out_c[0] = idx(0, H - 1); vecs[2].out_c[1] = idx(0, 0); vecs[2].out_c[2] = idx(0, 1);
    vecs[2].pop = 3;
`else
    vecs[2].nin = 3;  vecs[2].in_c[0] = idx(0, 0); vecs[2].in_c[1] = idx(1, 0); vecs[2].in_c[2] = idx(0, 1);
    vecs[2].nout = 4;
    vecs[2].out_c[0] = idx(0, 0); vecs[2].out_c[1] = idx(1, 0); vecs[2].out_c[2] = idx(0, 1); vecs[2].out_c[3] = idx(1, 1);
    vecs[2].pop = 4;
`endif
    // empty grid, birth on zero neighbours
    vecs[3].birth = 9'h001; vecs[3].survive = 9'h000; vecs[3].all_out = 1'b1; vecs[3].pop = N;
    // empty grid, B3/S23
    vecs[4].pop = 0;
    // lone cell survives only with S0
    vecs[5].birth = 9'h000; vecs[5].survive = 9'h001;
    vecs[5].nin = 1; vecs[5].in_c[0] = idx(7, 7); vecs[5].nout = 1; vecs[5].out_c[0] = idx(7, 7); vecs[5].pop = 1;
    // ring of 8: centre sees n=8
    vecs[6].birth = 9'h100; vecs[6].survive = 9'h000; vecs[6].nin = 8;
    vecs[6].in_c[0] = idx(3, 3); vecs[6].in_c[1] = idx(4, 3); vecs[6].in_c[2] = idx(5, 3); vecs[6].in_c[3] = idx(3, 4);
    vecs[6].in_c[4] = idx(5, 4); vecs[6].in_c[5] = idx(3, 5); vecs[6].in_c[6] = idx(4, 5); vecs[6].in_c[7] = idx(5, 5);
    vecs[6].nout = 1; vecs[6].out_c[0] = idx(4, 4); vecs[6].pop = 1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset bank", int'(bank), 0);
    chk("reset rd_addr", int'(rd_addr), 0);
    chk("reset wr_addr", int'(wr_addr), 0);
    chk("reset population", int'(population), 0);

    for (int v = 0; v < NV; v++) run_vec(vecs[v], v);

    // start pulsed mid-generation with different rules must be ignored
    load(vecs[0]);
    base = wr_total;
    pulse_start(vecs[0]);
    repeat (100) @(negedge clk);
    rule_birth = 9'h1FF; rule_survive = 9'h1FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < LAT + 300; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    exp_bank = ~exp_bank;
    chk("busy-start done pulses", dones, 1);
    chk("busy-start bank", int'(bank), int'(exp_bank));
    check_frame(vecs[0], 90, base);

    // reset mid-generation
    load(vecs[0]);
    pulse_start(vecs[0]);
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_bank = 1'b0;
    chk("midreset busy", int'(busy), 0);
    chk("midreset wr_en", int'(wr_en), 0);
    chk("midreset bank", int'(bank), 0);
    chk("midreset population", int'(population), 0);
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_total;
    repeat (300) @(negedge clk);
    chk("midreset writes after", wr_total - w0, 0);
    chk("midreset still idle", int'(busy), 0);
    run_vec(vecs[0], 91);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
